// File: rtl/lib_pkg.sv
// Shared library definitions: FIFO parameter defaults and the pointer/count width helper,
// so other blocks can size buses that carry a FIFO occupancy.
package lib_pkg;

    localparam int FIFO_WIDTH_DEF    = 32;
    localparam int FIFO_DEPTH_DEF    = 16;
    localparam int FIFO_AE_LEVEL_DEF = 2;

    // Index bits plus one wrap bit; also wide enough to hold a count of 0..depth.
    function automatic int ptr_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/fifo_mem.sv
// WIDTH x DEPTH storage array: synchronous write, asynchronous read.
// Generalised successor of the fixed 4096x32 memory.
module fifo_mem #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 16,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic             clock,
    input  logic             i_we,
    input  logic [AW-1:0]    i_waddr,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic [AW-1:0]    i_raddr,
    output logic [WIDTH-1:0] o_rdata
);

    logic [WIDTH-1:0] r_mem [DEPTH];

    // NOTE: storage has no reset so it maps onto RAM; <= keeps the write ordered like a flop.
    always_ff @(posedge clock) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/sync_fifo.sv
// First-word-fall-through synchronous FIFO with valid/ready on both sides, count and flush.
// Define SYNC_FIFO_THRESH_EN to enable the almost_full/almost_empty comparators.
module sync_fifo
    import lib_pkg::*;
#(
    parameter int WIDTH    = FIFO_WIDTH_DEF,
    parameter int DEPTH    = FIFO_DEPTH_DEF,
    parameter int AF_LEVEL = DEPTH - 2,
    parameter int AE_LEVEL = FIFO_AE_LEVEL_DEF
) (
    input  logic                        clock,
    input  logic                        reset_L,
    input  logic                        flush,
    input  logic [WIDTH-1:0]            in_data,
    input  logic                        in_valid,
    output logic                        in_ready,
    output logic [WIDTH-1:0]            out_data,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [ptr_width(DEPTH)-1:0] count,
    output logic                        almost_full,
    output logic                        almost_empty
);

    localparam int PW = ptr_width(DEPTH);
    localparam int AW = $clog2(DEPTH);

    logic [PW-1:0]    r_wr_ptr;
    logic [PW-1:0]    r_rd_ptr;
    logic [PW-1:0]    r_count;
    logic             w_in_ready;
    logic             w_out_valid;
    logic             w_push;
    logic             w_pop;
    logic [WIDTH-1:0] w_mem_rdata;

    // Handshake readiness comes from registered count only, never from the partner's valid/ready.
    assign w_in_ready  = (r_count != PW'(DEPTH));
    assign w_out_valid = (r_count != '0);
    assign w_push      = in_valid & w_in_ready;
    assign w_pop       = w_out_valid & out_ready;

    always_ff @(posedge clock or negedge reset_L) begin
        if (!reset_L) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    fifo_mem #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_mem (
        .clock   (clock),
        .i_we    (w_push & ~flush),
        .i_waddr (r_wr_ptr[AW-1:0]),
        .i_wdata (in_data),
        .i_raddr (r_rd_ptr[AW-1:0]),
        .o_rdata (w_mem_rdata)
    );

    assign in_ready  = w_in_ready;
    assign out_valid = w_out_valid;
    assign out_data  = w_out_valid ? w_mem_rdata : '0;
    assign count     = r_count;

`ifdef SYNC_FIFO_THRESH_EN
    localparam logic [PW-1:0] AF_CNT = PW'(AF_LEVEL);
    localparam logic [PW-1:0] AE_CNT = PW'(AE_LEVEL);

    assign almost_full  = (r_count >= AF_CNT);
    assign almost_empty = (r_count <= AE_CNT);
`else
    assign almost_full  = 1'b0;
    assign almost_empty = 1'b0;
`endif

endmodule

// File: tb/tb_sync_fifo.sv
// Directed self-checking bench for sync_fifo (DEPTH=16, WIDTH=32), valid with or without
// SYNC_FIFO_THRESH_EN defined.
module tb_sync_fifo;

    localparam int WIDTH = 32;
    localparam int DEPTH = 16;

    logic             clock;
    logic             reset_L;
    logic             flush;
    logic [WIDTH-1:0] in_data;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] out_data;
    logic             out_valid;
    logic             out_ready;
    logic [4:0]       count;
    logic             almost_full;
    logic             almost_empty;

    int n_tests = 0;
    int n_fail  = 0;

    sync_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) dut (
        .clock        (clock),
        .reset_L      (reset_L),
        .flush        (flush),
        .in_data      (in_data),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .out_data     (out_data),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .count        (count),
        .almost_full  (almost_full),
        .almost_empty (almost_empty)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Threshold flags expected for a given occupancy (AF_LEVEL=14, AE_LEVEL=2).
    function automatic logic exp_af(input int c);
`ifdef SYNC_FIFO_THRESH_EN
        return c >= 14;
`else
        return 1'b0;
`endif
    endfunction

    function automatic logic exp_ae(input int c);
`ifdef SYNC_FIFO_THRESH_EN
        return c <= 2;
`else
        return 1'b0;
`endif
    endfunction

    // Advance one clock; outputs are sampled 1 time unit after the edge.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check_state(input string tag, input int c);
        check({tag, " count"},     32'(count),        32'(c));
        check({tag, " in_ready"},  32'(in_ready),     32'(c != DEPTH));
        check({tag, " out_valid"}, 32'(out_valid),    32'(c != 0));
        check({tag, " af"},        32'(almost_full),  32'(exp_af(c)));
        check({tag, " ae"},        32'(almost_empty), 32'(exp_ae(c)));
    endtask

    task automatic check_reset_values(input string tag);
        check_state(tag, 0);
        check({tag, " out_data"}, out_data, 32'h0);
    endtask

    task automatic fill(input int n, input logic [31:0] base);
        for (int i = 0; i < n; i++) begin
            in_valid = 1'b1;
            in_data  = base + 32'(i);
            tick();
        end
        in_valid = 1'b0;
    endtask

    initial begin
        reset_L   = 1'b0;
        flush     = 1'b0;
        in_data   = '0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        #12;
        check_reset_values("in_reset");
        reset_L = 1'b1;
        tick();
        tick();
        check_reset_values("idle");

        // Fill 0x00..0x0F, checking count and flags at every occupancy.
        for (int i = 0; i < DEPTH; i++) begin
            in_valid = 1'b1;
            in_data  = 32'(i);
            tick();
            check_state($sformatf("fill%0d", i), i + 1);
        end
        check("full head", out_data, 32'h0);
        in_data = 32'hFF;
        tick();
        tick();
        check_state("drop17", DEPTH);
        in_valid = 1'b0;

        // Drain in order.
        out_ready = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            check($sformatf("pop%0d data", i), out_data, 32'(i));
            tick();
            check($sformatf("pop%0d count", i), 32'(count), 32'(DEPTH - 1 - i));
        end
        out_ready = 1'b0;
        check_reset_values("drained");

        // Steady state at 8 across pointer wrap.
        fill(8, 32'h100);
        check_state("half", 8);
        for (int k = 0; k < 40; k++) begin
            in_valid  = 1'b1;
            in_data   = 32'h108 + 32'(k);
            out_ready = 1'b1;
            check($sformatf("stream%0d data", k), out_data, 32'h100 + 32'(k));
            tick();
            check($sformatf("stream%0d count", k), 32'(count), 32'd8);
        end
        in_valid = 1'b0;
        for (int j = 0; j < 8; j++) begin
            check($sformatf("tail%0d data", j), out_data, 32'h128 + 32'(j));
            tick();
        end
        out_ready = 1'b0;
        check_state("tail_empty", 0);

        // Full with simultaneous push and pop: pop only, then push accepted.
        fill(DEPTH, 32'h200);
        check_state("full2", DEPTH);
        in_valid  = 1'b1;
        in_data   = 32'h2AA;
        out_ready = 1'b1;
        tick();
        check_state("full_pushpop", DEPTH - 1);
        check("full_pushpop head", out_data, 32'h201);
        out_ready = 1'b0;
        tick();
        check_state("refill", DEPTH);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int i = 1; i < DEPTH; i++) begin
            check($sformatf("full_drain%0d", i), out_data, 32'h200 + 32'(i));
            tick();
        end
        check("full_drain last", out_data, 32'h2AA);
        tick();
        out_ready = 1'b0;
        check_reset_values("full_drained");

        // Flush overrides simultaneous push and pop.
        fill(5, 32'h300);
        check_state("five", 5);
        flush     = 1'b1;
        in_valid  = 1'b1;
        in_data   = 32'h3FF;
        out_ready = 1'b1;
        tick();
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        check_reset_values("flushed");

        // Asynchronous reset mid-cycle with 5 entries.
        fill(5, 32'h400);
        check_state("five_b", 5);
        check("five_b head", out_data, 32'h400);
        #2;
        reset_L = 1'b0;
        #1;
        check_reset_values("async_rst");
        reset_L = 1'b1;
        tick();
        check_reset_values("post_rst");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
